sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO that succeeds the two-clock FIFO in the verification environment. It uses the same winc/wdata/wfull and rinc/rdata/rempty handshake. It adds:
- configurable depth and width
- an occupancy count
- programmable almost-full and almost-empty flags
- a selectable first-word-fall-through (FWFT) read mode

It is used as elastic buffering inside a single clock domain, between a producer and a consumer.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/sync_fifo_param_mem.sv | 38 +++
 rtl/sync_fifo_param.sv | 215 +++++++++++++++++++++
 tb/tb_sync_fifo_param.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the single-clock parametrised FIFO.
//   FIFO_DATA_WIDTH_DEF  default word width
//   FIFO_ADDR_WIDTH_DEF  default log2(depth)
//   fifo_mode_e          read-port mode (standard registered / first-word-fall-through)
//   fifo_mode_from_int   maps the integer FWFT parameter onto fifo_mode_e
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH_DEF = 8;
  localparam int FIFO_ADDR_WIDTH_DEF = 4;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Any non-zero FWFT value selects fall-through mode.
  function automatic fifo_mode_e fifo_mode_from_int(input int fwft);
    return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
  endfunction

endpackage : fifo_pkg

// File: rtl/sync_fifo_param_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// DEPTH x FIFO_DATA_WIDTH storage array for sync_fifo_param.
// Synchronous write, asynchronous (combinational) read. Contents are not reset.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write address  [FIFO_ADDR_WIDTH-1:0]
//   wdata  in   write data     [FIFO_DATA_WIDTH-1:0]
//   raddr  in   read address   [FIFO_ADDR_WIDTH-1:0]
//   rdata  out  read data      [FIFO_DATA_WIDTH-1:0], follows raddr combinationally
// -----------------------------------------------------------------------------
module fifo_mem #(
  parameter int FIFO_DATA_WIDTH = fifo_pkg::FIFO_DATA_WIDTH_DEF,
  parameter int FIFO_ADDR_WIDTH = fifo_pkg::FIFO_ADDR_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [FIFO_ADDR_WIDTH-1:0] waddr,
  input  logic [FIFO_DATA_WIDTH-1:0] wdata,
  input  logic [FIFO_ADDR_WIDTH-1:0] raddr,
  output logic [FIFO_DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;

  logic [FIFO_DATA_WIDTH-1:0] mem_q [DEPTH];

  // No reset on the array: the controller never exposes an unwritten slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : fifo_mem

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock elastic FIFO with occupancy count, programmable almost-full /
// almost-empty flags and a selectable read mode (registered or first-word-
// fall-through).
//
// Optional build macro: SYNC_FIFO_ERR_FLAGS_EN
//   When defined, adds sticky overflow/underflow error flags and an err_clr
//   input. When undefined those ports do not exist and rejected requests are
//   silently dropped.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   winc           in   write request
//   wdata          in   write data
//   wfull          out  FIFO holds DEPTH entries
//   walmost_full   out  count >= AFULL_THRESH
//   rinc           in   read request
//   rdata          out  read data (registered, or head word in FWFT mode)
//   rempty         out  no entry available
//   ralmost_empty  out  count <= AEMPTY_THRESH
//   count          out  occupancy 0..DEPTH
//   err_clr        in   (macro only) clears overflow/underflow, wins over set
//   overflow       out  (macro only) sticky: write attempted while full
//   underflow      out  (macro only) sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
  parameter int FIFO_ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF,
  parameter int AFULL_THRESH    = 12,
  parameter int AEMPTY_THRESH   = 2,
  parameter int FWFT            = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       winc,
  input  logic [FIFO_DATA_WIDTH-1:0] wdata,
  output logic                       wfull,
  output logic                       walmost_full,
  input  logic                       rinc,
  output logic [FIFO_DATA_WIDTH-1:0] rdata,
  output logic                       rempty,
  output logic                       ralmost_empty,
  output logic [FIFO_ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
 ,input  logic                       err_clr,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int              DEPTH    = 1 << FIFO_ADDR_WIDTH;
  localparam int              CW       = FIFO_ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]   AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0]   AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0]   ONE_C    = CW'(1);
  localparam fifo_mode_e      MODE     = fifo_mode_from_int(FWFT);

  // ---------------------------------------------------------------------------
  // Parameter legality
  // ---------------------------------------------------------------------------
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_param: AFULL_THRESH=%0d outside 1..%0d", AFULL_THRESH, DEPTH);
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_param: AEMPTY_THRESH=%0d outside 0..%0d", AEMPTY_THRESH, DEPTH - 1);
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("sync_fifo_param: FWFT=%0d must be 0 or 1", FWFT);
  end
  if (FIFO_ADDR_WIDTH < 1 || FIFO_DATA_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_param: widths must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Controller state
  // ---------------------------------------------------------------------------
  logic [CW-1:0]              wptr_q, wptr_d;
  logic [CW-1:0]              rptr_q, rptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       wr_en;
  logic                       rd_en;
  logic [FIFO_DATA_WIDTH-1:0] mem_rdata;

  // Flags come straight from the count register so no combinational path
  // exists from winc/rinc to any status output.
  assign wfull         = (count_q == DEPTH_C);
  assign rempty        = (count_q == '0);
  assign walmost_full  = (count_q >= AFULL_C);
  assign ralmost_empty = (count_q <= AEMPTY_C);
  assign count         = count_q;

  always_comb begin
    // Acceptance uses the flags as they stand at the start of the cycle, so a
    // simultaneous read on a full FIFO does not open room for the same-cycle
    // write, and vice versa on empty.
    wr_en   = winc && !wfull;
    rd_en   = rinc && !rempty;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    if (wr_en) begin
      wptr_d = wptr_q + ONE_C;
    end
    if (rd_en) begin
      rptr_d = rptr_q + ONE_C;
    end

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  fifo_mem #(
    .FIFO_DATA_WIDTH (FIFO_DATA_WIDTH),
    .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_q[FIFO_ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .raddr (rptr_q[FIFO_ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  if (MODE == FIFO_STD) begin : g_std_read
    logic [FIFO_DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Captures the head word on an accepted read; holds otherwise.
    always_comb begin
      rdata_d = rdata_q;
      if (rd_en) begin
        rdata_d = mem_rdata;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign rdata = rdata_q;
  end else begin : g_fwft_read
    // Head word is presented directly. Forced to zero while empty so the
    // port shows a clean value after reset instead of stale array contents.
    assign rdata = rempty ? '0 : mem_rdata;
  end

  // ---------------------------------------------------------------------------
  // Optional sticky error flags
  // ---------------------------------------------------------------------------
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (winc && wfull) begin
      overflow_d = 1'b1;
    end
    if (rinc && rempty) begin
      underflow_d = 1'b1;
    end
    // Clear wins over a set in the same cycle.
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Drives one registered-read instance and one FWFT instance from the same
// stimulus and checks both against hand-derived vectors and a queue model.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          winc  = 1'b0;
  logic          rinc  = 1'b0;
  logic [DW-1:0] wdata = '0;

  logic          s_wfull, s_waf, s_rempty, s_rae;
  logic [DW-1:0] s_rdata;
  logic [AW:0]   s_count;
  logic          f_wfull, f_waf, f_rempty, f_rae;
  logic [DW-1:0] f_rdata;
  logic [AW:0]   f_count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic          err_clr = 1'b0;
  logic          s_overflow, s_underflow, f_overflow, f_underflow;
`endif

  always #5 clk = ~clk;

  sync_fifo_param #(
    .FIFO_DATA_WIDTH (DW), .FIFO_ADDR_WIDTH (AW),
    .AFULL_THRESH (12), .AEMPTY_THRESH (2), .FWFT (0)
  ) dut_std (
    .clk (clk), .rst_n (rst_n),
    .winc (winc), .wdata (wdata), .wfull (s_wfull), .walmost_full (s_waf),
    .rinc (rinc), .rdata (s_rdata), .rempty (s_rempty), .ralmost_empty (s_rae),
    .count (s_count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   ,.err_clr (err_clr), .overflow (s_overflow), .underflow (s_underflow)
`endif
  );

  sync_fifo_param #(
    .FIFO_DATA_WIDTH (DW), .FIFO_ADDR_WIDTH (AW),
    .AFULL_THRESH (12), .AEMPTY_THRESH (2), .FWFT (1)
  ) dut_fwft (
    .clk (clk), .rst_n (rst_n),
    .winc (winc), .wdata (wdata), .wfull (f_wfull), .walmost_full (f_waf),
    .rinc (rinc), .rdata (f_rdata), .rempty (f_rempty), .ralmost_empty (f_rae),
    .count (f_count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   ,.err_clr (err_clr), .overflow (f_overflow), .underflow (f_underflow)
`endif
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    cmp_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          winc;
    logic [DW-1:0] wdata;
    logic          rinc;
    logic [AW:0]   count;
    logic          rempty;
    logic          wfull;
    logic          waf;
    logic          rae;
    logic          chk_rd;
    logic [DW-1:0] rdata;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [DW-1:0] wd, input logic r,
                              input logic [AW:0] cnt, input logic re, input logic wf,
                              input logic af, input logic ae, input logic chk,
                              input logic [DW-1:0] rd);
    vec_t v;
    v.winc = w; v.wdata = wd; v.rinc = r; v.count = cnt; v.rempty = re;
    v.wfull = wf; v.waf = af; v.rae = ae; v.chk_rd = chk; v.rdata = rd;
    return v;
  endfunction

  localparam int NVEC = 35;
  vec_t          vecs [NVEC];
  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] exp_word;
  logic          acc_w, acc_r;
  int            wprob, rprob;

  initial begin
    // ---------------- vector table: fill, boundaries, drain ----------------
    for (int k = 0; k < 16; k++) begin
      vecs[k] = mk(1'b1, DW'(k), 1'b0, (AW+1)'(k + 1), 1'b0, (k == 15),
                   ((k + 1) >= 12), ((k + 1) <= 2), 1'b0, 8'h00);
    end
    // write on full: dropped
    vecs[16] = mk(1'b1, 8'hAA, 1'b0, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    // write+read on full: only the read is accepted
    vecs[17] = mk(1'b1, 8'hBB, 1'b1, 5'd15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 1; i < 16; i++) begin
      vecs[17 + i] = mk(1'b0, 8'h00, 1'b1, (AW+1)'(15 - i), (i == 15), 1'b0,
                        ((15 - i) >= 12), ((15 - i) <= 2), 1'b1, DW'(i));
    end
    // write+read on empty: only the write is accepted, rdata holds
    vecs[33] = mk(1'b1, 8'h77, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0F);
    vecs[34] = mk(1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77);

    // ---------------- reset state ----------------
    repeat (6) tick();
    check("rst_rempty", 32'(s_rempty), 32'd1);
    check("rst_wfull", 32'(s_wfull), 32'd0);
    check("rst_waf", 32'(s_waf), 32'd0);
    check("rst_rae", 32'(s_rae), 32'd1);
    check("rst_count", 32'(s_count), 32'd0);
    check("rst_rdata", 32'(s_rdata), 32'd0);
    check("rst_f_rempty", 32'(f_rempty), 32'd1);
    check("rst_f_count", 32'(f_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // ---------------- table-driven run ----------------
    for (int k = 0; k < NVEC; k++) begin
      winc  = vecs[k].winc;
      wdata = vecs[k].wdata;
      rinc  = vecs[k].rinc;
      tick();
      check($sformatf("vec%0d_count", k), 32'(s_count), 32'(vecs[k].count));
      check($sformatf("vec%0d_rempty", k), 32'(s_rempty), 32'(vecs[k].rempty));
      check($sformatf("vec%0d_wfull", k), 32'(s_wfull), 32'(vecs[k].wfull));
      check($sformatf("vec%0d_waf", k), 32'(s_waf), 32'(vecs[k].waf));
      check($sformatf("vec%0d_rae", k), 32'(s_rae), 32'(vecs[k].rae));
      check($sformatf("vec%0d_f_count", k), 32'(f_count), 32'(vecs[k].count));
      if (vecs[k].chk_rd) begin
        check($sformatf("vec%0d_rdata", k), 32'(s_rdata), 32'(vecs[k].rdata));
      end
    end
    winc = 1'b0;
    rinc = 1'b0;

    // ---------------- asynchronous reset mid-burst ----------------
    for (int i = 0; i < 7; i++) begin
      winc  = 1'b1;
      wdata = DW'(8'h40 + i);
      tick();
    end
    winc = 1'b0;
    check("burst_count", 32'(s_count), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(s_count), 32'd0);
    check("async_rst_rempty", 32'(s_rempty), 32'd1);
    check("async_rst_f_count", 32'(f_count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    winc  = 1'b1;
    wdata = 8'h3C;
    tick();
    winc = 1'b0;
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    check("post_rst_rdata", 32'(s_rdata), 32'h3C);
    check("post_rst_rempty", 32'(s_rempty), 32'd1);

    // ---------------- FWFT single word ----------------
    winc  = 1'b1;
    wdata = 8'h5C;
    tick();
    winc = 1'b0;
    check("fwft_rempty", 32'(f_rempty), 32'd0);
    check("fwft_rdata", 32'(f_rdata), 32'h5C);
    check("std_rempty_1cyc", 32'(s_rempty), 32'd0);
    tick();
    check("fwft_rdata_hold", 32'(f_rdata), 32'h5C);
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    check("fwft_pop_rempty", 32'(f_rempty), 32'd1);
    check("std_pop_rdata", 32'(s_rdata), 32'h5C);

    // ---------------- random traffic against a queue model ----------------
    sb_q.delete();
    for (int ph = 0; ph < 4; ph++) begin
      wprob = (ph % 2 == 0) ? 80 : 25;
      rprob = (ph % 2 == 0) ? 30 : 80;
      for (int c = 0; c < 50; c++) begin
        winc  = ($urandom_range(0, 99) < wprob);
        rinc  = ($urandom_range(0, 99) < rprob);
        wdata = DW'($urandom_range(0, 255));
        acc_w = winc && (sb_q.size() < DEPTH);
        acc_r = rinc && (sb_q.size() > 0);
        if (sb_q.size() > 0) begin
          check("rnd_fwft_head", 32'(f_rdata), 32'(sb_q[0]));
        end
        exp_word = '0;
        if (acc_r) exp_word = sb_q.pop_front();
        if (acc_w) sb_q.push_back(wdata);
        tick();
        if (acc_r) begin
          check("rnd_std_rdata", 32'(s_rdata), 32'(exp_word));
        end
        check("rnd_count", 32'(s_count), 32'(sb_q.size()));
        check("rnd_f_count", 32'(f_count), 32'(sb_q.size()));
        check("rnd_rempty", 32'(s_rempty), 32'(sb_q.size() == 0));
        check("rnd_wfull", 32'(s_wfull), 32'(sb_q.size() == DEPTH));
      end
    end
    winc = 1'b0;
    rinc = 1'b0;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // ---------------- sticky error flags ----------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("err_rst_underflow", 32'(s_underflow), 32'd0);
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    check("underflow_set", 32'(s_underflow), 32'd1);
    check("f_underflow_set", 32'(f_underflow), 32'd1);
    tick();
    check("underflow_sticky", 32'(s_underflow), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("underflow_clr", 32'(s_underflow), 32'd0);
    for (int i = 0; i < 17; i++) begin
      winc  = 1'b1;
      wdata = DW'(i);
      tick();
      if (i == 15) check("overflow_not_yet", 32'(s_overflow), 32'd0);
    end
    winc = 1'b0;
    check("overflow_set", 32'(s_overflow), 32'd1);
    check("overflow_count", 32'(s_count), 32'd16);
    check("f_overflow_set", 32'(f_overflow), 32'd1);
    winc    = 1'b1;
    err_clr = 1'b1;
    tick();
    winc    = 1'b0;
    err_clr = 1'b0;
    check("clr_priority", 32'(s_overflow), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule : tb_sync_fifo_param
